stack_mem: RTL and testbench

STACK_MEM -- requirements
Module: stack_mem

---
 rtl/stack_mem.sv | 129 ++++++++++++
 tb/tb_stack_mem.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/stack_mem.sv
// stack_mem: DATA_LEN-wide, 2**ADDR_LEN-deep LIFO with registered pop data.
// A push and a pop on the same edge replace the top entry; on an empty stack
// that case is a plain push.
// Overflow and underflow requests are ignored and leave no state behind.
// Optional feature: define STK_ERR_FLAG_EN to build a sticky stk_err flag.
// The flag latches any overflow or underflow and clears only on rst.
// Without the macro, stk_err is tied low.
module stack_mem #(
  parameter int DATA_LEN = 8,
  parameter int ADDR_LEN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stk_push,
  input  logic                stk_pop,
  input  logic [DATA_LEN-1:0] stk_data_in,
  output logic [DATA_LEN-1:0] stk_data_out,
  output logic                stk_valid,
  output logic [ADDR_LEN:0]   stk_count,
  output logic                stk_full,
  output logic                stk_empty,
  output logic                stk_err
);

  localparam int DEPTH = 2 ** ADDR_LEN;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stk_op_e;

  logic [DATA_LEN-1:0] mem [DEPTH];

  logic                push_req;
  logic                pop_req;
  stk_op_e             op;
  logic [ADDR_LEN:0]   count_m1;
  logic [ADDR_LEN-1:0] top_idx;
  logic [ADDR_LEN-1:0] wr_idx;

  // A request counts only when it is a solid 1; x/z from a released driver is idle.
  assign push_req = (stk_push === 1'b1);
  assign pop_req  = (stk_pop === 1'b1);

  // Status flags are decoded from the registered count only.
  assign stk_full  = (stk_count == (ADDR_LEN+1)'(DEPTH));
  assign stk_empty = (stk_count == '0);

  assign count_m1 = stk_count - (ADDR_LEN+1)'(1);
  assign top_idx  = count_m1[ADDR_LEN-1:0];

  // Decide which stack operation, if any, is legal this cycle.
  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    op = OP_NONE;
    if (push_req && pop_req) begin
      op = stk_empty ? OP_PUSH : OP_REPLACE;
    end else if (push_req) begin
      op = stk_full ? OP_NONE : OP_PUSH;
    end else if (pop_req) begin
      op = stk_empty ? OP_NONE : OP_POP;
    end
  end

  // A plain push writes the next free slot; replace-top rewrites the current top.
  assign wr_idx = (op == OP_PUSH) ? stk_count[ADDR_LEN-1:0] : top_idx;

  // Storage array write port.
  // NOTE: the memory array is deliberately not reset; it stays a plain RAM, and
  // slots at or above stk_count are never read.
  always_ff @(posedge clk) begin
    if (!rst && (op == OP_PUSH || op == OP_REPLACE)) begin
      mem[wr_idx] <= stk_data_in;
    end
  end

  // Count, pop data and the valid pulse. rst overrides any request on the same edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    if (rst) begin
      stk_count    <= '0;
      stk_data_out <= '0;
      stk_valid    <= 1'b0;
    end else begin
      stk_valid <= 1'b0;
      unique case (op)
        OP_PUSH: stk_count <= stk_count + (ADDR_LEN+1)'(1);
        OP_POP: begin
          stk_data_out <= mem[top_idx];
          stk_count    <= count_m1;
          stk_valid    <= 1'b1;
        end
        OP_REPLACE: begin
          stk_data_out <= mem[top_idx];
          stk_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef STK_ERR_FLAG_EN
  logic overflow;
  logic underflow;
  logic err_q;

  // An overflow is a lone push when the stack is full; an underflow is any pop
  // when the stack is empty.
  assign overflow  = push_req && !pop_req && stk_full;
  assign underflow = pop_req && stk_empty;

  // Sticky error flag, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (overflow || underflow) begin
      err_q <= 1'b1;
    end
  end

  assign stk_err = err_q;
`else
  assign stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_mem.sv
// tb_stack_mem: directed self-checking bench for stack_mem.
// The expected stk_err values follow STK_ERR_FLAG_EN.
module tb_stack_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;
  logic       stk_valid;
  logic [4:0] stk_count;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;

  int checks   = 0;
  int failures = 0;

`ifdef STK_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  stack_mem #(.DATA_LEN(8), .ADDR_LEN(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .stk_push    (stk_push),
    .stk_pop     (stk_pop),
    .stk_data_in (stk_data_in),
    .stk_data_out(stk_data_out),
    .stk_valid   (stk_valid),
    .stk_count   (stk_count),
    .stk_full    (stk_full),
    .stk_empty   (stk_empty),
    .stk_err     (stk_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive the inputs on the falling edge, take one rising edge, then let outputs settle.
  task automatic step(input logic r, input logic p, input logic q, input logic [7:0] d);
    @(negedge clk);
    rst = r; stk_push = p; stk_pop = q; stk_data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Release both request lines to z for one edge.
  task automatic zstep();
    @(negedge clk);
    rst = 1'b0; stk_push = 1'bz; stk_pop = 1'bz; stk_data_in = 8'hEE;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] op1;
    logic [7:0] op2;
    logic [7:0] res;
    rst = 1'b1; stk_push = 1'b0; stk_pop = 1'b0; stk_data_in = 8'h00;

    // Reset state
    step(1, 0, 0, 8'h00);
    check("rst_count", stk_count, 0);
    check("rst_empty", stk_empty, 1);
    check("rst_full",  stk_full,  0);
    check("rst_valid", stk_valid, 0);
    check("rst_data",  stk_data_out, 8'h00);
    check("rst_err",   stk_err, 0);

    // Basic LIFO: push 05, push 03, pop, pop
    step(0, 1, 0, 8'h05);
    step(0, 1, 0, 8'h03);
    check("lifo_count2", stk_count, 2);
    check("lifo_valid0", stk_valid, 0);
    step(0, 0, 1, 8'h00);
    check("lifo_pop1_data",  stk_data_out, 8'h03);
    check("lifo_pop1_valid", stk_valid, 1);
    check("lifo_pop1_count", stk_count, 1);
    step(0, 0, 1, 8'h00);
    check("lifo_pop2_data",  stk_data_out, 8'h05);
    check("lifo_pop2_valid", stk_valid, 1);
    check("lifo_pop2_count", stk_count, 0);
    check("lifo_empty", stk_empty, 1);
    step(0, 0, 0, 8'h00);
    check("hold_valid", stk_valid, 0);
    check("hold_data",  stk_data_out, 8'h05);

    // Underflow: pop on an empty stack
    step(0, 0, 1, 8'h00);
    check("uf_valid", stk_valid, 0);
    check("uf_data",  stk_data_out, 8'h05);
    check("uf_count", stk_count, 0);
    check("uf_err",   stk_err, ERR_EN);

    // Fill to full, then overflow
    step(1, 0, 0, 8'h00);
    check("rst2_err", stk_err, 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 8'h10 + 8'(i));
    check("full_flag",  stk_full, 1);
    check("full_count", stk_count, 16);
    check("full_empty", stk_empty, 0);
    check("full_err0",  stk_err, 0);
    step(0, 1, 0, 8'hAA);
    check("of_count", stk_count, 16);
    check("of_err",   stk_err, ERR_EN);
    step(0, 0, 1, 8'h00);
    check("of_pop_data",  stk_data_out, 8'h1F);
    check("of_pop_valid", stk_valid, 1);
    check("of_pop_count", stk_count, 15);
    check("of_pop_full",  stk_full, 0);
    step(0, 0, 1, 8'h00);
    check("of_pop2_data", stk_data_out, 8'h1E);

    // Replace-top: stack holds 07, push 09 and pop together
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h07);
    step(0, 1, 1, 8'h09);
    check("rep_data",  stk_data_out, 8'h07);
    check("rep_valid", stk_valid, 1);
    check("rep_count", stk_count, 1);
    step(0, 0, 1, 8'h00);
    check("rep_pop_data",  stk_data_out, 8'h09);
    check("rep_pop_count", stk_count, 0);
    check("rep_err", stk_err, 0);

    // Push and pop together on an empty stack: push only, pop is an underflow
    step(1, 0, 0, 8'h00);
    step(0, 1, 1, 8'h33);
    check("epp_count", stk_count, 1);
    check("epp_valid", stk_valid, 0);
    check("epp_data",  stk_data_out, 8'h00);
    check("epp_err",   stk_err, ERR_EN);
    step(0, 0, 1, 8'h00);
    check("epp_pop_data", stk_data_out, 8'h33);

    // Released (z) request lines followed by a subtract consumer sequence
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h02);
    step(0, 1, 0, 8'h04);
    for (int i = 0; i < 3; i++) zstep();
    check("z_count", stk_count, 2);
    check("z_valid", stk_valid, 0);
    check("z_err",   stk_err, 0);
    op1 = 8'h04; op2 = 8'h02; res = op2 - op1;
    step(0, 0, 1, 8'h00);
    check("alu_op1", stk_data_out, op1);
    step(0, 0, 1, 8'h00);
    check("alu_op2", stk_data_out, op2);
    step(0, 1, 0, res);
    check("alu_count", stk_count, 1);
    step(0, 0, 1, 8'h00);
    check("alu_res", stk_data_out, 8'hFE);
    check("alu_empty", stk_empty, 1);

    // rst wins over a simultaneous pop, leaving the stack empty
    step(1, 0, 0, 8'h00);
    step(0, 1, 0, 8'h11);
    step(0, 1, 0, 8'h22);
    step(1, 0, 1, 8'h00);
    check("rstpop_count", stk_count, 0);
    check("rstpop_valid", stk_valid, 0);
    check("rstpop_data",  stk_data_out, 8'h00);
    check("rstpop_err",   stk_err, 0);
    step(0, 0, 1, 8'h00);
    check("post_rst_uf_valid", stk_valid, 0);
    check("post_rst_uf_data",  stk_data_out, 8'h00);
    check("post_rst_uf_err",   stk_err, ERR_EN);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
